// File: rtl/heap_alloc_pkg.sv
// heap_alloc_pkg: shared constants and types for the linked-memory heap allocator.
// Holds type tags, the UNDEF/NIL/TRUE/FALSE/UNIT/ZERO constants, error codes,
// request encodings and FSM states.
package heap_alloc_pkg;

  localparam logic [15:0] MUT_TAG = 16'h4000;
  localparam logic [15:0] VLT_TAG = 16'h1000;

  localparam logic [15:0] UNDEF = 16'h0000;
  localparam logic [15:0] NIL   = 16'h0001;
  localparam logic [15:0] TRUE  = 16'h0002;
  localparam logic [15:0] FALSE = 16'h0003;
  localparam logic [15:0] UNIT  = 16'h0004;
  localparam logic [15:0] ZERO  = 16'h8000;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OOM     = 2'd1,
    ERR_BAD_PTR = 2'd2,
    ERR_BAD_OP  = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Request encodings as {alloc, free, rd, wr}
  typedef enum logic [3:0] {
    OP_NONE  = 4'b0000,
    OP_ALLOC = 4'b1000,
    OP_FREE  = 4'b0100,
    OP_SWAP  = 4'b1100,
    OP_RD    = 4'b0010,
    OP_WR    = 4'b0001,
    OP_RDWR  = 4'b0011
  } op_t;

endpackage

// File: rtl/heap_alloc_if.sv
// heap_alloc_if: request/response bundle between the cons-cell engine (master)
// and the heap allocator (slave).
interface heap_alloc_if #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
);
  logic               o_ready;
  logic               i_alloc;
  logic               i_free;
  logic               i_wr;
  logic               i_rd;
  logic [DATA_SZ-1:0] i_data;
  logic [DATA_SZ-1:0] i_addr;
  logic [DATA_SZ-1:0] i_waddr;
  logic [DATA_SZ-1:0] i_wdata;
  logic [DATA_SZ-1:0] i_raddr;
  logic               o_valid;
  logic [DATA_SZ-1:0] o_addr;
  logic [DATA_SZ-1:0] o_rdata;
  logic               o_err;
  logic [1:0]         o_err_code;
  logic [ADDR_SZ:0]   o_used;
  logic [ADDR_SZ:0]   o_hiwat;

  modport master (
    output i_alloc, i_free, i_wr, i_rd, i_data, i_addr, i_waddr, i_wdata, i_raddr,
    input  o_ready, o_valid, o_addr, o_rdata, o_err, o_err_code, o_used, o_hiwat
  );

  modport slave (
    input  i_alloc, i_free, i_wr, i_rd, i_data, i_addr, i_waddr, i_wdata, i_raddr,
    output o_ready, o_valid, o_addr, o_rdata, o_err, o_err_code, o_used, o_hiwat
  );
endinterface

// File: rtl/heap_alloc_bram.sv
// heap_alloc_bram: simple dual-port block RAM, one write and one registered
// read port; a read of the address being written returns the old contents.
module heap_alloc_bram #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata
);
  logic [DATA_SZ-1:0] mem [1<<ADDR_SZ];

  // Write port and read-first registered read port
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end
endmodule

// File: rtl/heap_alloc.sv
// heap_alloc: linked-memory heap allocator over one BRAM. Cells are handed out
// from a bump pointer (mem_top) or recycled from a free list threaded through
// the cells themselves. Optional feature macro: ALLOC_STATS_EN (o_used/o_hiwat).
module heap_alloc
  import heap_alloc_pkg::*;
#(
  parameter int                 DATA_SZ = 16,
  parameter int                 ADDR_SZ = 8,
  parameter int                 MEM_MAX = (1 << ADDR_SZ),
  parameter logic [DATA_SZ-1:0] PTR_TAG = 16'h5000
) (
  input logic         i_clk,
  input logic         i_rst,
  heap_alloc_if.slave bus
);
  localparam logic [ADDR_SZ:0]         TOP_MAX = (ADDR_SZ+1)'(MEM_MAX);
  localparam logic [DATA_SZ-ADDR_SZ-1:0] TAG_HI = PTR_TAG[DATA_SZ-1:ADDR_SZ];
  localparam logic [DATA_SZ-1:0]       P_NIL   = DATA_SZ'(NIL);
  localparam logic [DATA_SZ-1:0]       P_UNDEF = DATA_SZ'(UNDEF);

  state_t             state, state_nx;
  err_code_t          err_q, err_nx;
  logic [ADDR_SZ:0]   mem_top, mem_top_nx;
  logic [ADDR_SZ:0]   free_cnt, free_cnt_nx;
  logic [DATA_SZ-1:0] mem_next, mem_next_nx;
  logic [DATA_SZ-1:0] next_link, next_link_nx;
  logic               valid_q, valid_nx;
  logic [DATA_SZ-1:0] addr_q, addr_nx;
  logic               rd_q, rd_nx;
  logic               we;
  logic [ADDR_SZ-1:0] waddr, raddr;
  logic [DATA_SZ-1:0] wdata, bram_rdata;
  logic [3:0]         op;

  function automatic logic ptr_ok(input logic [DATA_SZ-1:0] p, input logic [ADDR_SZ:0] top);
    return (p[DATA_SZ-1:ADDR_SZ] == TAG_HI) && ({1'b0, p[ADDR_SZ-1:0]} < top);
  endfunction

  assign op = {bus.i_alloc, bus.i_free, bus.i_rd, bus.i_wr};

  heap_alloc_bram #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ)) u_bram (
    .i_clk   (i_clk),
    .i_we    (we && !i_rst),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_raddr (raddr),
    .o_rdata (bram_rdata)
  );

  // Request decode, free-list bookkeeping and next-state selection
  always_comb begin
    state_nx     = state;
    err_nx       = err_q;
    mem_top_nx   = mem_top;
    free_cnt_nx  = free_cnt;
    mem_next_nx  = mem_next;
    next_link_nx = next_link;
    valid_nx     = 1'b0;
    addr_nx      = P_UNDEF;
    rd_nx        = 1'b0;
    we           = 1'b0;
    waddr        = '0;
    wdata        = '0;
    raddr        = bus.i_raddr[ADDR_SZ-1:0];
    unique case (state)
      ST_RUN: begin
        case (op)
          OP_NONE: ;
          OP_ALLOC: begin
            if (mem_next != P_NIL) begin
              // Pop the head; its successor's link is read now and latched in FETCH
              valid_nx    = 1'b1;
              addr_nx     = mem_next;
              we          = 1'b1;
              waddr       = mem_next[ADDR_SZ-1:0];
              wdata       = bus.i_data;
              mem_next_nx = next_link;
              raddr       = next_link[ADDR_SZ-1:0];
              free_cnt_nx = free_cnt - (ADDR_SZ+1)'(1);
              if (next_link != P_NIL) state_nx = ST_FETCH;
            end else if (mem_top < TOP_MAX) begin
              valid_nx   = 1'b1;
              addr_nx    = PTR_TAG | DATA_SZ'(mem_top);
              we         = 1'b1;
              waddr      = mem_top[ADDR_SZ-1:0];
              wdata      = bus.i_data;
              mem_top_nx = mem_top + (ADDR_SZ+1)'(1);
            end else begin
              state_nx = ST_HALT;
              err_nx   = ERR_OOM;
            end
          end
          OP_FREE: begin
            if (ptr_ok(bus.i_addr, mem_top)) begin
              we           = 1'b1;
              waddr        = bus.i_addr[ADDR_SZ-1:0];
              wdata        = mem_next;
              next_link_nx = mem_next;
              mem_next_nx  = bus.i_addr;
              free_cnt_nx  = free_cnt + (ADDR_SZ+1)'(1);
            end else begin
              state_nx = ST_HALT;
              err_nx   = ERR_BAD_PTR;
            end
          end
          OP_SWAP: begin
            if (ptr_ok(bus.i_addr, mem_top)) begin
              valid_nx = 1'b1;
              addr_nx  = bus.i_addr;
              we       = 1'b1;
              waddr    = bus.i_addr[ADDR_SZ-1:0];
              wdata    = bus.i_data;
            end else begin
              state_nx = ST_HALT;
              err_nx   = ERR_BAD_PTR;
            end
          end
          OP_RD, OP_WR, OP_RDWR: begin
            if ((!bus.i_rd || ptr_ok(bus.i_raddr, mem_top)) &&
                (!bus.i_wr || ptr_ok(bus.i_waddr, mem_top))) begin
              valid_nx = bus.i_rd;
              rd_nx    = bus.i_rd;
              we       = bus.i_wr;
              waddr    = bus.i_waddr[ADDR_SZ-1:0];
              wdata    = bus.i_wdata;
            end else begin
              state_nx = ST_HALT;
              err_nx   = ERR_BAD_PTR;
            end
          end
          default: begin
            state_nx = ST_HALT;
            err_nx   = ERR_BAD_OP;
          end
        endcase
      end
      ST_FETCH: begin
        if (op != OP_NONE) begin
          state_nx = ST_HALT;
          err_nx   = ERR_BAD_OP;
        end else begin
          next_link_nx = bram_rdata;
          state_nx     = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  // Control state and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_RUN;
      err_q     <= ERR_NONE;
      mem_top   <= '0;
      free_cnt  <= '0;
      mem_next  <= P_NIL;
      next_link <= P_NIL;
      valid_q   <= 1'b0;
      addr_q    <= P_UNDEF;
      rd_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      err_q     <= err_nx;
      mem_top   <= mem_top_nx;
      free_cnt  <= free_cnt_nx;
      mem_next  <= mem_next_nx;
      next_link <= next_link_nx;
      valid_q   <= valid_nx;
      addr_q    <= addr_nx;
      rd_q      <= rd_nx;
    end
  end

  assign bus.o_ready    = (state == ST_RUN);
  assign bus.o_err      = (state == ST_HALT);
  assign bus.o_err_code = err_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_addr     = addr_q;
  assign bus.o_rdata    = rd_q ? bram_rdata : P_UNDEF;

`ifdef ALLOC_STATS_EN
  logic [ADDR_SZ:0] used_q, hiwat_q, used_nx;

  // Live-cell count derived from accepted allocs and frees
  always_comb begin
    used_nx = used_q;
    if (state == ST_RUN && op == OP_ALLOC && valid_nx)
      used_nx = used_q + (ADDR_SZ+1)'(1);
    else if (state == ST_RUN && op == OP_FREE && we && used_q != '0)
      used_nx = used_q - (ADDR_SZ+1)'(1);
  end

  // Usage and high-water registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      used_q  <= '0;
      hiwat_q <= '0;
    end else begin
      used_q <= used_nx;
      if (used_nx > hiwat_q) hiwat_q <= used_nx;
    end
  end

  assign bus.o_used  = used_q;
  assign bus.o_hiwat = hiwat_q;
`else
  assign bus.o_used  = '0;
  assign bus.o_hiwat = '0;
`endif

endmodule

// File: tb/tb_heap_alloc.sv
// tb_heap_alloc: directed scoreboard bench for heap_alloc. Two instances: a
// full-size heap (ADDR_SZ=8) and a 4-cell heap (ADDR_SZ=2) for exhaustion.
module tb_heap_alloc;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;
  logic [16:0] exp_a[$];
  logic [16:0] exp_b[$];

  always #5 clk = ~clk;

  heap_alloc_if #(.DATA_SZ(16), .ADDR_SZ(8)) ifa ();
  heap_alloc_if #(.DATA_SZ(16), .ADDR_SZ(2)) ifb ();

  heap_alloc #(.DATA_SZ(16), .ADDR_SZ(8)) dut_a (.i_clk(clk), .i_rst(rst_a), .bus(ifa));
  heap_alloc #(.DATA_SZ(16), .ADDR_SZ(2), .MEM_MAX(4)) dut_b (.i_clk(clk), .i_rst(rst_b), .bus(ifb));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor for the full-size heap: pop an expectation per o_valid
  always @(negedge clk) begin
    logic [16:0] e;
    if (ifa.o_valid === 1'b1) begin
      if (exp_a.size() == 0) check("a_unexpected_valid", 32'(ifa.o_valid), 32'd0);
      else begin
        e = exp_a.pop_front();
        if (e[16]) check("a_rdata", 32'(ifa.o_rdata), 32'(e[15:0]));
        else       check("a_addr",  32'(ifa.o_addr),  32'(e[15:0]));
      end
    end
  end

  // Monitor for the 4-cell heap
  always @(negedge clk) begin
    logic [16:0] e;
    if (ifb.o_valid === 1'b1) begin
      if (exp_b.size() == 0) check("b_unexpected_valid", 32'(ifb.o_valid), 32'd0);
      else begin
        e = exp_b.pop_front();
        if (e[16]) check("b_rdata", 32'(ifb.o_rdata), 32'(e[15:0]));
        else       check("b_addr",  32'(ifb.o_addr),  32'(e[15:0]));
      end
    end
  end

  task automatic idle_all();
    ifa.i_alloc = 0; ifa.i_free = 0; ifa.i_rd = 0; ifa.i_wr = 0;
    ifa.i_data = '0; ifa.i_addr = '0; ifa.i_raddr = '0; ifa.i_waddr = '0; ifa.i_wdata = '0;
    ifb.i_alloc = 0; ifb.i_free = 0; ifb.i_rd = 0; ifb.i_wr = 0;
    ifb.i_data = '0; ifb.i_addr = '0; ifb.i_raddr = '0; ifb.i_waddr = '0; ifb.i_wdata = '0;
  endtask

  // One request cycle; op = {alloc, free, rd, wr}; addr feeds all pointer inputs
  task automatic drv(input bit b, input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    if (!b) begin
      ifa.i_alloc = op[3]; ifa.i_free = op[2]; ifa.i_rd = op[1]; ifa.i_wr = op[0];
      ifa.i_addr = addr; ifa.i_raddr = addr; ifa.i_waddr = addr;
      ifa.i_data = data; ifa.i_wdata = data;
    end else begin
      ifb.i_alloc = op[3]; ifb.i_free = op[2]; ifb.i_rd = op[1]; ifb.i_wr = op[0];
      ifb.i_addr = addr; ifb.i_raddr = addr; ifb.i_waddr = addr;
      ifb.i_data = data; ifb.i_wdata = data;
    end
    @(posedge clk);
    #1 idle_all();
  endtask

  task automatic reset_dut(input bit b);
    @(negedge clk);
    #1;
    if (!b) begin rst_a = 1; exp_a.delete(); end
    else    begin rst_b = 1; exp_b.delete(); end
    repeat (2) @(posedge clk);
    #1;
    if (!b) rst_a = 0; else rst_b = 0;
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (ifa.o_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_timeout", 32'(ifa.o_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    idle_all();
    rst_a = 1; rst_b = 1;
    repeat (3) @(posedge clk);
    #1 rst_a = 0; rst_b = 0;

    // Reset state
    @(negedge clk);
    check("a_rst_ready", 32'(ifa.o_ready),    32'd1);
    check("a_rst_valid", 32'(ifa.o_valid),    32'd0);
    check("a_rst_err",   32'(ifa.o_err),      32'd0);
    check("a_rst_code",  32'(ifa.o_err_code), 32'd0);
    check("a_rst_addr",  32'(ifa.o_addr),     32'h0000);
    check("a_rst_used",  32'(ifa.o_used),     32'd0);

    // Bump allocation and read-back
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back({1'b0, 16'h5000 + 16'(i)});
      drv(0, 4'b1000, 16'h0000, 16'h1234);
    end
    exp_a.push_back({1'b1, 16'h1234});
    drv(0, 4'b0010, 16'h5001, 16'h0000);

    // Free-list reuse with link refetch stall
    drv(0, 4'b0100, 16'h5001, 16'h0000);
    drv(0, 4'b0100, 16'h5000, 16'h0000);
    exp_a.push_back({1'b0, 16'h5000});
    drv(0, 4'b1000, 16'h0000, 16'hAAAA);
    @(negedge clk);
    check("a_fetch_ready", 32'(ifa.o_ready), 32'd0);
    wait_ready_a();
    exp_a.push_back({1'b0, 16'h5001});
    drv(0, 4'b1000, 16'h0000, 16'hBBBB);
    exp_a.push_back({1'b0, 16'h5003});
    drv(0, 4'b1000, 16'h0000, 16'hCCCC);
    exp_a.push_back({1'b1, 16'hAAAA}); drv(0, 4'b0010, 16'h5000, 16'h0000);
    exp_a.push_back({1'b1, 16'hBBBB}); drv(0, 4'b0010, 16'h5001, 16'h0000);
    exp_a.push_back({1'b1, 16'hCCCC}); drv(0, 4'b0010, 16'h5003, 16'h0000);

    // Pass-through alloc+free, then free list still empty
    exp_a.push_back({1'b0, 16'h5002}); drv(0, 4'b1100, 16'h5002, 16'h7777);
    exp_a.push_back({1'b1, 16'h7777}); drv(0, 4'b0010, 16'h5002, 16'h0000);
    exp_a.push_back({1'b0, 16'h5004}); drv(0, 4'b1000, 16'h0000, 16'h4444);
    // Read-first on simultaneous rd+wr, then new data next cycle
    exp_a.push_back({1'b1, 16'hAAAA}); drv(0, 4'b0011, 16'h5000, 16'h1111);
    exp_a.push_back({1'b1, 16'h1111}); drv(0, 4'b0010, 16'h5000, 16'h0000);
    drv(0, 4'b0001, 16'h5003, 16'hDDDD);
    exp_a.push_back({1'b1, 16'hDDDD}); drv(0, 4'b0010, 16'h5003, 16'h0000);
    @(negedge clk);
    check("a_no_err", 32'(ifa.o_err), 32'd0);

    // Bad tag
    reset_dut(0);
    drv(0, 4'b0100, 16'h0005, 16'h0000);
    @(negedge clk);
    check("a_badtag_err",   32'(ifa.o_err),      32'd1);
    check("a_badtag_code",  32'(ifa.o_err_code), 32'd2);
    check("a_badtag_ready", 32'(ifa.o_ready),    32'd0);
    drv(0, 4'b1000, 16'h0000, 16'h9999);
    @(negedge clk);
    check("a_halt_hold_code", 32'(ifa.o_err_code), 32'd2);

    // Index at mem_top
    reset_dut(0);
    exp_a.push_back({1'b0, 16'h5000}); drv(0, 4'b1000, 16'h0000, 16'h0001);
    drv(0, 4'b0100, 16'h5001, 16'h0000);
    @(negedge clk);
    check("a_top_code", 32'(ifa.o_err_code), 32'd2);

    // Illegal op mix
    reset_dut(0);
    drv(0, 4'b1010, 16'h0000, 16'h0000);
    @(negedge clk);
    check("a_badop_code", 32'(ifa.o_err_code), 32'd3);

    // Request while fetching a link
    reset_dut(0);
    exp_a.push_back({1'b0, 16'h5000}); drv(0, 4'b1000, 16'h0000, 16'h0001);
    exp_a.push_back({1'b0, 16'h5001}); drv(0, 4'b1000, 16'h0000, 16'h0002);
    drv(0, 4'b0100, 16'h5000, 16'h0000);
    drv(0, 4'b0100, 16'h5001, 16'h0000);
    exp_a.push_back({1'b0, 16'h5001}); drv(0, 4'b1000, 16'h0000, 16'h0003);
    drv(0, 4'b1000, 16'h0000, 16'h0004);
    @(negedge clk);
    check("a_fetch_op_err",  32'(ifa.o_err),      32'd1);
    check("a_fetch_op_code", 32'(ifa.o_err_code), 32'd3);

    // Usage statistics
    reset_dut(0);
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back({1'b0, 16'h5000 + 16'(i)});
      drv(0, 4'b1000, 16'h0000, 16'h00F0);
    end
    drv(0, 4'b0100, 16'h5000, 16'h0000);
    drv(0, 4'b0100, 16'h5001, 16'h0000);
    exp_a.push_back({1'b0, 16'h5001}); drv(0, 4'b1000, 16'h0000, 16'h00F1);
    @(negedge clk);
    wait_ready_a();
`ifdef ALLOC_STATS_EN
    check("a_used",  32'(ifa.o_used),  32'd2);
    check("a_hiwat", 32'(ifa.o_hiwat), 32'd3);
`else
    check("a_used",  32'(ifa.o_used),  32'd0);
    check("a_hiwat", 32'(ifa.o_hiwat), 32'd0);
`endif

    // Exhaustion on the 4-cell heap
    for (int i = 0; i < 4; i++) begin
      exp_b.push_back({1'b0, 16'h5000 + 16'(i)});
      drv(1, 4'b1000, 16'h0000, 16'h0100 + 16'(i));
    end
    drv(1, 4'b1000, 16'h0000, 16'h0200);
    @(negedge clk);
    check("b_oom_err",   32'(ifb.o_err),      32'd1);
    check("b_oom_code",  32'(ifb.o_err_code), 32'd1);
    check("b_oom_ready", 32'(ifb.o_ready),    32'd0);
    reset_dut(1);
    @(negedge clk);
    check("b_rst_err",   32'(ifb.o_err),      32'd0);
    check("b_rst_code",  32'(ifb.o_err_code), 32'd0);
    check("b_rst_ready", 32'(ifb.o_ready),    32'd1);
    exp_b.push_back({1'b0, 16'h5000}); drv(1, 4'b1000, 16'h0000, 16'h0300);

    repeat (3) @(negedge clk);
    check("a_queue_drain", 32'(exp_a.size()), 32'd0);
    check("b_queue_drain", 32'(exp_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
